// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with 3-sample majority vote,
// input synchroniser, false-start rejection and parity/framing flags.
// Ports: clk, rst (sync, active-high), baud (oversample tick),
//   rx_in (async line, idle high), rx_data/rx_valid (received word +
//   1-cycle strobe), rx_busy (frame in progress), parity_err, frame_err.
module uart_rx_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TC_S0   = TW'(OVERSAMPLE - 3);
  localparam logic [TW-1:0] TC_S1   = TW'(OVERSAMPLE - 2);
  localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BC_SLAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]          tc_q;
  logic [BW-1:0]          bc_q;
  logic                   armed_q;
  logic                   s0_q;
  logic                   s1_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   perr_q;
  logic                   ferr_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   rx_busy_q;
  logic                   parity_err_q;
  logic                   frame_err_q;

  logic                 rx_s;
  logic                 in_bit;
  logic                 tick_last;
  logic                 maj_d;
  logic                 par_d;
  logic                 perr_d;
  logic                 ferr_d;
  logic [DATA_BITS-1:0] shift_d;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    in_bit    = (state_q == DATA) || (state_q == PARITY) ||
                (state_q == STOP);
    tick_last = baud && (tc_q == TC_LAST);
    // third sample is taken live on the decision tick
    maj_d     = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    par_d     = (^shift_q) ^ maj_d;
    perr_d    = (PARITY_MODE == 2) ? ~par_d : par_d;
    ferr_d    = ferr_q | ~maj_d;
    shift_d   = {maj_d, shift_q[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '1;
      state_q      <= IDLE;
      tc_q         <= '0;
      bc_q         <= '0;
      armed_q      <= 1'b0;
      s0_q         <= 1'b0;
      s1_q         <= 1'b0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_busy_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_in};
      rx_valid_q <= 1'b0;

      if (baud && in_bit) begin
        if (tc_q == TC_S0) s0_q <= rx_s;
        if (tc_q == TC_S1) s1_q <= rx_s;
        tc_q <= (tc_q == TC_LAST) ? '0 : tc_q + 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          tc_q <= '0;
          bc_q <= '0;
          if (rx_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q   <= START;
            rx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (baud) begin
            if (tc_q == TC_HALF) begin
              tc_q <= '0;
              if (rx_s) begin
                state_q   <= IDLE;
                rx_busy_q <= 1'b0;
              end else begin
                state_q <= DATA;
                bc_q    <= '0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
              end
            end else begin
              tc_q <= tc_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick_last) begin
            shift_q <= shift_d;
            if (bc_q == BC_DLAST) begin
              bc_q    <= '0;
              state_q <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bc_q <= bc_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick_last) begin
            perr_q  <= perr_d;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (tick_last) begin
            if (bc_q == BC_SLAST) begin
              // finish mid-stop-bit so a back-to-back start is not missed
              state_q      <= IDLE;
              bc_q         <= '0;
              rx_valid_q   <= 1'b1;
              rx_data_q    <= shift_q;
              parity_err_q <= perr_q;
              frame_err_q  <= ferr_d;
              rx_busy_q    <= 1'b0;
              armed_q      <= 1'b0;
            end else begin
              bc_q   <= bc_q + 1'b1;
              ferr_q <= ferr_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_busy    = rx_busy_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule
